moore_detector1101: RTL and testbench

- Moore finite-state machine that detects the serial bit pattern 1101 on input x, one bit sampled per rising clock edge.
- Overlapping occurrences are detected.
- Output z is high for exactly the cycle(s) the FSM sits in the detect state.
- Used as a small sequence-recognition leaf block; detection is enabled by start.

---
 rtl/moore_detector1101.sv | 47 ++++
 tb/tb_moore_detector1101.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/moore_detector1101.sv
// Moore FSM detecting the serial pattern 1101 on x, with overlap.
// z is decoded from the state alone; start=0 or an illegal code returns to a.
module moore_detector1101 (
    input  logic x,
    input  logic start,
    input  logic reset,
    input  logic clock,
    output logic z
);

    typedef enum logic [2:0] {
        a = 3'd0,
        b = 3'd1,
        c = 3'd2,
        d = 3'd3,
        e = 3'd4
    } state_t;

    state_t current;
    state_t next_state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            current <= a;
        end else begin
            current <= next_state;
        end
    end

    // start has priority over x; codes 5..7 fall through to the default.
    always_comb begin
        next_state = a;
        if (start) begin
            case (current)
                a:       next_state = x ? b : a;
                b:       next_state = x ? c : a;
                c:       next_state = x ? c : d;
                d:       next_state = x ? e : a;
                e:       next_state = x ? c : a;
                default: next_state = a;
            endcase
        end
    end

    assign z = (current == e);

endmodule

// File: tb/tb_moore_detector1101.sv
// Self-checking bench for moore_detector1101: vector table, hand sequences
// for reset/start corner cases, and random stimulus against a history model.
module tb_moore_detector1101;

    logic x;
    logic start;
    logic reset;
    logic clock;
    logic z;

    int tests_run = 0;
    int tests_failed = 0;

    bit   hist[$];
    logic exp_q[$];

    typedef struct {
        bit x;
        bit start;
        bit z;
    } vec_t;

    vec_t tbl[$];

    moore_detector1101 dut (
        .x     (x),
        .start (start),
        .reset (reset),
        .clock (clock),
        .z     (z)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: z is high exactly when the last four bits sampled with
    // start=1 since the last reset or start=0 read 1,1,0,1.
    task automatic model_step(input bit xv, input bit sv);
        int n;
        if (!sv) begin
            hist.delete();
        end else begin
            hist.push_back(xv);
            if (hist.size() > 8) void'(hist.pop_front());
        end
        n = hist.size();
        exp_q.push_back((n >= 4) && hist[n-4] && hist[n-3] && !hist[n-2] && hist[n-1]);
    endtask

    task automatic model_reset();
        hist.delete();
        exp_q.delete();
    endtask

    // Drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input bit xv, input bit sv, input string name, input int exp_st);
        logic ez;
        @(negedge clock);
        x = xv;
        start = sv;
        model_step(xv, sv);
        @(posedge clock);
        #1;
        ez = exp_q.pop_front();
        check({name, "_z"}, {2'b00, z}, {2'b00, ez});
        if (exp_st >= 0) check({name, "_state"}, dut.current, exp_st[2:0]);
    endtask

    task automatic push_vec(input bit xv, input bit sv, input bit zv);
        vec_t v;
        v.x = xv;
        v.start = sv;
        v.z = zv;
        tbl.push_back(v);
    endtask

    initial begin
        // Basic detect, then overlap (1101101), then e -> a on 0.
        push_vec(1, 1, 0); push_vec(1, 1, 0); push_vec(0, 1, 0); push_vec(1, 1, 1);
        push_vec(1, 1, 0); push_vec(0, 1, 0); push_vec(1, 1, 1); push_vec(0, 1, 0);
        // Near miss 11101 detects once; 1001 never detects.
        push_vec(1, 1, 0); push_vec(1, 1, 0); push_vec(1, 1, 0); push_vec(0, 1, 0);
        push_vec(1, 1, 1); push_vec(0, 1, 0);
        push_vec(1, 1, 0); push_vec(0, 1, 0); push_vec(0, 1, 0); push_vec(1, 1, 0);
        push_vec(0, 1, 0);
        // start=0 suppresses a full 1101.
        push_vec(1, 0, 0); push_vec(1, 0, 0); push_vec(0, 0, 0); push_vec(1, 0, 0);
        // Reach d, then start drops on the completing 1.
        push_vec(1, 1, 0); push_vec(1, 1, 0); push_vec(0, 1, 0); push_vec(1, 0, 0);
        push_vec(1, 1, 0);

        // Reset held for two edges with random x.
        x = 1'b0;
        start = 1'b1;
        reset = 1'b0;
        #1;
        check("reset_async_z", {2'b00, z}, 3'd0);
        check("reset_async_state", dut.current, 3'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            x = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
            check("reset_hold_z", {2'b00, z}, 3'd0);
            check("reset_hold_state", dut.current, 3'd0);
        end
        @(negedge clock);
        reset = 1'b1;
        model_reset();

        // Table-driven vectors.
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            x = tbl[i].x;
            start = tbl[i].start;
            model_step(tbl[i].x, tbl[i].start);
            @(posedge clock);
            #1;
            void'(exp_q.pop_front());
            check($sformatf("vec%0d_z", i), {2'b00, z}, {2'b00, tbl[i].z});
        end

        // State walk for basic detect and overlap.
        step(0, 1, "walk0", 0);
        step(1, 1, "walk1", 1);
        step(1, 1, "walk2", 2);
        step(0, 1, "walk3", 3);
        step(1, 1, "walk4", 4);
        step(1, 1, "walk5", 2);
        step(0, 1, "walk6", 3);
        step(1, 1, "walk7", 4);
        step(0, 1, "walk8", 0);

        // Asynchronous reset from d, mid-cycle.
        step(1, 1, "mid_a", 1);
        step(1, 1, "mid_b", 2);
        step(0, 1, "mid_c", 3);
        #3;
        reset = 1'b0;
        #1;
        check("mid_reset_state", dut.current, 3'd0);
        check("mid_reset_z", {2'b00, z}, 3'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        step(1, 1, "post_a", 1);
        step(1, 1, "post_b", 2);
        step(0, 1, "post_c", 3);
        step(1, 1, "post_d", 4);

        // Asynchronous reset while z is high drops z at once.
        #3;
        reset = 1'b0;
        #1;
        check("reset_in_e_z", {2'b00, z}, 3'd0);
        check("reset_in_e_state", dut.current, 3'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;

        // Random stimulus, x biased to 1 to produce frequent matches.
        for (int i = 0; i < 600; i++) begin
            step(bit'($urandom_range(0, 9) < 6), bit'($urandom_range(0, 15) != 0), "rand", -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
